// File: rtl/sevga_pkg.sv
// rtl/sevga_pkg.sv - shared constants, FIFO entry type and state enums for the VRAM write path
package sevga_pkg;

  // Frame-buffer window in CPU word addresses (cpuAddr[14:1])
  localparam logic [13:0] FB_WORD_BASE  = 14'h1380;
  localparam logic [13:0] FB_WORD_LIMIT = 14'h3E40;

  // One captured CPU word write
  typedef struct packed {
    logic [13:0] off;
    logic [15:0] data;
    logic        ube;
    logic        lbe;
  } wr_entry_t;

  typedef enum logic [1:0] {
    CAP_ARM  = 2'd0,
    CAP_IDLE = 2'd1,
    CAP_HOLD = 2'd2
  } cap_state_t;

  typedef enum logic [1:0] {
    EM_EMPTY = 2'd0,
    EM_HI    = 2'd1,
    EM_LO    = 2'd2
  } em_state_t;

  // VRAM byte address: word offset with the byte lane as LSB (0 = upper byte)
  function automatic logic [14:0] vram_byte_addr(input logic [13:0] off, input logic lo);
    return {off, lo};
  endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// rtl/vram_wr_fifo.sv - synchronous FIFO of captured writes with head/next peek and occupancy
module vram_wr_fifo
  import sevga_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  wr_entry_t              i_push_data,
  input  logic                   i_pop,
  output wr_entry_t              o_head,
  output wr_entry_t              o_next,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_push_ok
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_FULL = DEPTH[AW:0];

  wr_entry_t       r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic [AW-1:0]   w_rd_nxt;
  logic            w_pop;
  logic            w_push_ok;

  // A pop only happens with data present; a push into a full FIFO is allowed when a pop frees the slot
  assign w_pop     = i_pop && (r_count != '0);
  assign w_push_ok = i_push && ((r_count < LP_FULL) || w_pop);
  assign w_rd_nxt  = r_rd_ptr + 1'b1;

  assign o_head    = r_mem[r_rd_ptr];
  assign o_next    = r_mem[w_rd_nxt];
  assign o_count   = r_count;
  assign o_push_ok = w_push_ok;

  // Storage array; contents are qualified by the count so it needs no reset
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_nxt;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vram_wr_capture.sv
// rtl/vram_wr_capture.sv - capture CPU frame-buffer writes and replay them as VRAM byte writes (option macro: VRAM_WR_RANGE_CHECK_EN)
module vram_wr_capture
  import sevga_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   pixClk,
  input  logic                   nReset,
  input  logic [23:1]            cpuAddr,
  input  logic [15:0]            cpuData,
  input  logic                   ncpuAS,
  input  logic                   ncpuUDS,
  input  logic                   ncpuLDS,
  input  logic                   cpuRnW,
  input  logic [2:0]             ramSize,
  output logic                   wrReq,
  output logic [14:0]            wrAddr,
  output logic [7:0]             wrData,
  input  logic                   wrAck,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] qLevel
);

  localparam int AW = $clog2(DEPTH);
  // Sync vector order {RnW, LDS, UDS, AS}; strobes reset to asserted so a cycle in flight at reset is never seen idle
  localparam logic [3:0] SYNC_RST = 4'b1000;

  logic [3:0]  r_sync1;
  logic [3:0]  r_sync2;
  logic        w_as;
  logic        w_uds;
  logic        w_lds;
  logic        w_rnw;

  logic [13:0] w_word;
  logic [13:0] w_off;
  logic        w_range_ok;
  logic        w_hit;
  logic        w_unused_a15;

  cap_state_t  r_cap_state;
  cap_state_t  w_cap_next;
  logic        w_cap_fire;
  logic        r_cap_vld;
  wr_entry_t   r_cap_entry;

  wr_entry_t   w_head;
  wr_entry_t   w_next;
  logic [AW:0] w_count;
  logic        w_push_ok;
  logic        w_pop;

  em_state_t   r_em_state;
  em_state_t   w_em_next;
  logic        r_wrReq;
  logic [14:0] r_wrAddr;
  logic [7:0]  r_wrData;
  logic        w_req_next;
  logic [14:0] w_addr_next;
  logic [7:0]  w_data_next;
  logic        w_load;
  wr_entry_t   w_load_entry;
  logic        r_overflow;

  // Two-flop synchronizers on the CPU strobes and direction
  always_ff @(posedge pixClk or negedge nReset) begin
    if (!nReset) begin
      r_sync1 <= SYNC_RST;
      r_sync2 <= SYNC_RST;
    end else begin
      r_sync1 <= {cpuRnW, ncpuLDS, ncpuUDS, ncpuAS};
      r_sync2 <= r_sync1;
    end
  end

  assign w_as  = r_sync2[0];
  assign w_uds = r_sync2[1];
  assign w_lds = r_sync2[2];
  assign w_rnw = r_sync2[3];

  // A15 is a mirror of the frame buffer and deliberately not decoded
  assign w_unused_a15 = cpuAddr[15];

  assign w_word = cpuAddr[14:1];
  assign w_off  = w_word - FB_WORD_BASE;

`ifdef VRAM_WR_RANGE_CHECK_EN
  assign w_range_ok = (w_word >= FB_WORD_BASE) && (w_word < FB_WORD_LIMIT);
`else
  assign w_range_ok = 1'b1;
`endif

  assign w_hit = (cpuAddr[23:22] == 2'b00) && (cpuAddr[21:19] == ramSize) &&
                 (cpuAddr[18:16] == 3'b111) && !w_rnw && w_range_ok;

  // Capture FSM next state: arm on an idle bus, push once per bus cycle, wait for strobe release
  always_comb begin
    w_cap_next = r_cap_state;
    w_cap_fire = 1'b0;
    case (r_cap_state)
      CAP_ARM: begin
        if (w_as && w_uds && w_lds) begin
          w_cap_next = CAP_IDLE;
        end
      end
      CAP_IDLE: begin
        if (!w_as && (!w_uds || !w_lds) && w_hit) begin
          w_cap_fire = 1'b1;
          w_cap_next = CAP_HOLD;
        end
      end
      CAP_HOLD: begin
        if (w_as && w_uds && w_lds) begin
          w_cap_next = CAP_IDLE;
        end
      end
      default: w_cap_next = CAP_ARM;
    endcase
  end

  // Capture state and the registered push toward the FIFO
  always_ff @(posedge pixClk or negedge nReset) begin
    if (!nReset) begin
      r_cap_state <= CAP_ARM;
      r_cap_vld   <= 1'b0;
      r_cap_entry <= '0;
    end else begin
      r_cap_state <= w_cap_next;
      r_cap_vld   <= w_cap_fire;
      if (w_cap_fire) begin
        r_cap_entry <= '{off: w_off, data: cpuData, ube: ~w_uds, lbe: ~w_lds};
      end
    end
  end

  vram_wr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (pixClk),
    .i_rst_n     (nReset),
    .i_push      (r_cap_vld),
    .i_push_data (r_cap_entry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_next      (w_next),
    .o_count     (w_count),
    .o_push_ok   (w_push_ok)
  );

  // Emitter next state: walk enabled bytes upper-first, pop after the last ack, chain straight into the next entry
  always_comb begin
    w_em_next    = r_em_state;
    w_req_next   = r_wrReq;
    w_addr_next  = r_wrAddr;
    w_data_next  = r_wrData;
    w_pop        = 1'b0;
    w_load       = 1'b0;
    w_load_entry = w_head;
    case (r_em_state)
      EM_EMPTY: begin
        if (w_count != '0) begin
          w_load = 1'b1;
        end
      end
      EM_HI: begin
        if (wrAck) begin
          if (w_head.lbe) begin
            w_em_next   = EM_LO;
            w_addr_next = vram_byte_addr(w_head.off, 1'b1);
            w_data_next = w_head.data[7:0];
          end else begin
            w_pop = 1'b1;
            if (w_count[AW:1] != '0) begin
              w_load       = 1'b1;
              w_load_entry = w_next;
            end else begin
              w_em_next  = EM_EMPTY;
              w_req_next = 1'b0;
            end
          end
        end
      end
      EM_LO: begin
        if (wrAck) begin
          w_pop = 1'b1;
          if (w_count[AW:1] != '0) begin
            w_load       = 1'b1;
            w_load_entry = w_next;
          end else begin
            w_em_next  = EM_EMPTY;
            w_req_next = 1'b0;
          end
        end
      end
      default: begin
        w_em_next  = EM_EMPTY;
        w_req_next = 1'b0;
      end
    endcase
    if (w_load) begin
      w_req_next = 1'b1;
      if (w_load_entry.ube) begin
        w_em_next   = EM_HI;
        w_addr_next = vram_byte_addr(w_load_entry.off, 1'b0);
        w_data_next = w_load_entry.data[15:8];
      end else begin
        w_em_next   = EM_LO;
        w_addr_next = vram_byte_addr(w_load_entry.off, 1'b1);
        w_data_next = w_load_entry.data[7:0];
      end
    end
  end

  // Emitter state and registered write-slot outputs
  always_ff @(posedge pixClk or negedge nReset) begin
    if (!nReset) begin
      r_em_state <= EM_EMPTY;
      r_wrReq    <= 1'b0;
      r_wrAddr   <= '0;
      r_wrData   <= '0;
    end else begin
      r_em_state <= w_em_next;
      r_wrReq    <= w_req_next;
      r_wrAddr   <= w_addr_next;
      r_wrData   <= w_data_next;
    end
  end

  // Sticky drop flag: a capture arrived while the FIFO was full and nothing left it
  always_ff @(posedge pixClk or negedge nReset) begin
    if (!nReset) begin
      r_overflow <= 1'b0;
    end else if (r_cap_vld && !w_push_ok) begin
      r_overflow <= 1'b1;
    end
  end

  assign wrReq    = r_wrReq;
  assign wrAddr   = r_wrAddr;
  assign wrData   = r_wrData;
  assign overflow = r_overflow;
  assign qLevel   = w_count;

endmodule

// File: tb/tb_vram_wr_capture.sv
// tb/tb_vram_wr_capture.sv - self-checking bench for vram_wr_capture
module tb_vram_wr_capture;

  localparam int DEPTH = 4;

  logic                   pixClk = 1'b0;
  logic                   nReset;
  logic [23:1]            cpuAddr;
  logic [15:0]            cpuData;
  logic                   ncpuAS;
  logic                   ncpuUDS;
  logic                   ncpuLDS;
  logic                   cpuRnW;
  logic [2:0]             ramSize;
  logic                   wrReq;
  logic [14:0]            wrAddr;
  logic [7:0]             wrData;
  logic                   wrAck;
  logic                   overflow;
  logic [$clog2(DEPTH):0] qLevel;

  int checks = 0;
  int errors = 0;
  int ack_mode = 0;
  int req_seen = 0;
  logic [22:0] exp_q[$];

  vram_wr_capture #(.DEPTH(DEPTH)) dut (
    .pixClk   (pixClk),
    .nReset   (nReset),
    .cpuAddr  (cpuAddr),
    .cpuData  (cpuData),
    .ncpuAS   (ncpuAS),
    .ncpuUDS  (ncpuUDS),
    .ncpuLDS  (ncpuLDS),
    .cpuRnW   (cpuRnW),
    .ramSize  (ramSize),
    .wrReq    (wrReq),
    .wrAddr   (wrAddr),
    .wrData   (wrData),
    .wrAck    (wrAck),
    .overflow (overflow),
    .qLevel   (qLevel)
  );

  always #8 pixClk = ~pixClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // wrAck driver: 0 = held low, 1 = random (mostly high), 2 = held high
  initial begin
    wrAck = 1'b0;
    forever begin
      @(posedge pixClk);
      #1;
      case (ack_mode)
        1:       wrAck = ($urandom_range(0, 3) != 0);
        2:       wrAck = 1'b1;
        default: wrAck = 1'b0;
      endcase
    end
  end

  // Scoreboard: every accepted byte must be the oldest expected one
  always @(negedge pixClk) begin
    if (nReset && wrReq) begin
      req_seen++;
      if (wrAck) begin
        if (exp_q.size() == 0) begin
          chk("byte_expected", 32'(exp_q.size()), 32'd1);
        end else begin
          logic [22:0] e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(wrAddr), 32'(e[22:8]));
          chk("wr_data", 32'(wrData), 32'(e[7:0]));
        end
      end
    end
  end

  // Reference: a write hits when it targets the frame-buffer block of the installed RAM size
  function automatic bit model_hit(input logic [23:0] a, input logic rnw, input logic [2:0] rs);
    logic [13:0] w;
    bit h;
    w = a[14:1];
    h = (a[23:22] == 2'b00) && (a[21:19] == rs) && (a[18:16] == 3'b111) && !rnw;
`ifdef VRAM_WR_RANGE_CHECK_EN
    h = h && (w >= 14'h1380) && (w < 14'h3E40);
`endif
    return h;
  endfunction

  task automatic model_push(input logic [23:0] a, input logic [15:0] d,
                            input logic ube, input logic lbe, input logic rnw);
    logic [13:0] off;
    if (model_hit(a, rnw, ramSize) && (ube || lbe)) begin
      off = a[14:1] - 14'h1380;
      if (ube) exp_q.push_back({off, 1'b0, d[15:8]});
      if (lbe) exp_q.push_back({off, 1'b1, d[7:0]});
    end
  endtask

  task automatic cpu_cycle(input logic [23:0] a, input logic [15:0] d,
                           input logic ube, input logic lbe, input logic rnw);
    @(posedge pixClk);
    #1;
    cpuAddr = a[23:1];
    cpuData = d;
    cpuRnW  = rnw;
    ncpuAS  = 1'b0;
    ncpuUDS = ~ube;
    ncpuLDS = ~lbe;
    repeat (5) @(posedge pixClk);
    #1;
    ncpuAS  = 1'b1;
    ncpuUDS = 1'b1;
    ncpuLDS = 1'b1;
    cpuRnW  = 1'b1;
    repeat (3) @(posedge pixClk);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || wrReq || qLevel != '0) && n < 300) begin
      @(posedge pixClk);
      n++;
    end
    #1;
    chk(tag, 32'(n < 300), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] a;
    logic [15:0] d;
    logic        ube;
    logic        lbe;
    logic        rnw;
    int          r0;

    nReset  = 1'b0;
    cpuAddr = '0;
    cpuData = '0;
    ncpuAS  = 1'b1;
    ncpuUDS = 1'b1;
    ncpuLDS = 1'b1;
    cpuRnW  = 1'b1;
    ramSize = 3'b111;
    repeat (3) @(posedge pixClk);
    #1;
    chk("rst_wrReq", 32'(wrReq), 32'd0);
    chk("rst_wrAddr", 32'(wrAddr), 32'd0);
    chk("rst_wrData", 32'(wrData), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_qLevel", 32'(qLevel), 32'd0);
    nReset = 1'b1;
    repeat (4) @(posedge pixClk);

    // Word write, wrAck high: latency and upper-then-lower order
    ack_mode = 2;
    @(posedge pixClk);
    model_push(24'h3FA700, 16'hA55A, 1'b1, 1'b1, 1'b0);
    @(posedge pixClk);
    #1;
    cpuAddr = 23'(24'h3FA700 >> 1);
    cpuData = 16'hA55A;
    cpuRnW  = 1'b0;
    ncpuAS  = 1'b0;
    ncpuUDS = 1'b0;
    ncpuLDS = 1'b0;
    @(posedge pixClk);
    repeat (3) @(posedge pixClk);
    #1;
    chk("lat_n3_low", 32'(wrReq), 32'd0);
    @(posedge pixClk);
    #1;
    chk("lat_n4_high", 32'(wrReq), 32'd1);
    repeat (2) @(posedge pixClk);
    #1;
    ncpuAS  = 1'b1;
    ncpuUDS = 1'b1;
    ncpuLDS = 1'b1;
    cpuRnW  = 1'b1;
    repeat (3) @(posedge pixClk);
    wait_drain("t1_drain");

    // Lower byte only
    r0 = req_seen;
    model_push(24'h3FA702, 16'h00C3, 1'b0, 1'b1, 1'b0);
    cpu_cycle(24'h3FA702, 16'h00C3, 1'b0, 1'b1, 1'b0);
    wait_drain("t2_drain");
    chk("t2_one_byte", 32'(req_seen - r0), 32'd1);

    // Just below the frame-buffer base
    d = 16'($urandom);
    model_push(24'h3FA6FE, d, 1'b1, 1'b0, 1'b0);
    cpu_cycle(24'h3FA6FE, d, 1'b1, 1'b0, 1'b0);
    wait_drain("t3_drain");

    // Read cycle is ignored
    r0 = req_seen;
    model_push(24'h3FA700, 16'h1234, 1'b1, 1'b1, 1'b1);
    cpu_cycle(24'h3FA700, 16'h1234, 1'b1, 1'b1, 1'b1);
    chk("t4_no_req", 32'(req_seen - r0), 32'd0);
    chk("t4_qLevel", 32'(qLevel), 32'd0);

    // Randomized traffic with random back-pressure
    ack_mode = 1;
    ramSize  = 3'($urandom_range(0, 7));
    for (int i = 0; i < 40; i++) begin
      a = {2'b00, ramSize, 3'b111, 15'($urandom), 1'b0};
      if ($urandom_range(0, 5) == 0) a[23:16] = 8'($urandom);
      d   = 16'($urandom);
      ube = 1'($urandom);
      lbe = 1'($urandom);
      rnw = ($urandom_range(0, 7) == 0);
      model_push(a, d, ube, lbe, rnw);
      cpu_cycle(a, d, ube, lbe, rnw);
    end
    ack_mode = 2;
    wait_drain("rand_drain");
    chk("rand_no_overflow", 32'(overflow), 32'd0);

    // Five word writes with wrAck low: four queued, fifth dropped
    ack_mode = 0;
    ramSize  = 3'b111;
    repeat (2) @(posedge pixClk);
    for (int i = 0; i < 5; i++) begin
      a = {8'h3F, 1'b1, 14'(14'h1380 + 14'($urandom_range(0, 14'h2ABF))), 1'b0};
      d = 16'($urandom);
      if (i < 4) model_push(a, d, 1'b1, 1'b1, 1'b0);
      cpu_cycle(a, d, 1'b1, 1'b1, 1'b0);
    end
    #1;
    chk("ovf_qLevel", 32'(qLevel), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_req_held", 32'(wrReq), 32'd1);
    ack_mode = 2;
    wait_drain("ovf_drain");
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Reset during an active CPU write; released while strobes are still low
    r0 = req_seen;
    @(posedge pixClk);
    #1;
    cpuAddr = 23'(24'h3FA704 >> 1);
    cpuData = 16'hBEEF;
    cpuRnW  = 1'b0;
    ncpuAS  = 1'b0;
    ncpuUDS = 1'b0;
    @(posedge pixClk);
    #1;
    nReset = 1'b0;
    repeat (2) @(posedge pixClk);
    #1;
    chk("mid_rst_qLevel", 32'(qLevel), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    nReset = 1'b1;
    repeat (4) @(posedge pixClk);
    #1;
    ncpuAS  = 1'b1;
    ncpuUDS = 1'b1;
    ncpuLDS = 1'b1;
    cpuRnW  = 1'b1;
    repeat (6) @(posedge pixClk);
    #1;
    chk("mid_rst_no_req", 32'(req_seen - r0), 32'd0);
    chk("mid_rst_q_empty", 32'(qLevel), 32'd0);

    model_push(24'h3FA706, 16'h5AA5, 1'b1, 1'b1, 1'b0);
    cpu_cycle(24'h3FA706, 16'h5AA5, 1'b1, 1'b1, 1'b0);
    wait_drain("post_rst_drain");
    chk("post_rst_bytes", 32'(req_seen - r0), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
